bus_master_arbiter: RTL and testbench

Arbitrates ownership of the 68000 bus between the CPU and two alternate bus masters: requester 0 (monitor port) and requester 1 (DMA port). It runs the 68000 BR/BG/BGACK bus-request handshake and grants the bus to one requester at a time. It bounds both the wait for BG and the grant tenure. It sits beside BusControl; the top level inverts its BR/BGACK outputs onto BR_n/BGACK_n.

---
 rtl/bus_master_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_master_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: 68000 BR/BG/BGACK bus arbiter for a monitor port (0) and a DMA port (1).
// Define BUS_ARB_ROUND_ROBIN_EN to alternate ties; otherwise requester 0 has fixed priority.
module bus_master_arbiter #(
    parameter int BG_TIMEOUT = 64,
    parameter int MAX_TENURE = 1024
) (
    input  logic MCLK_IN,
    input  logic RESET_n_IN,
    input  logic RUN_IN,
    input  logic BG_IN,
    input  logic AS_IN,
    input  logic REQ0_IN,
    input  logic REQ1_IN,
    input  logic CLEAR_ERR_IN,
    output logic BR,
    output logic BGACK,
    output logic GNT0,
    output logic GNT1,
    output logic BG_ERR,
    output logic ABORT
);
    localparam int WW = $clog2(BG_TIMEOUT) + 1;
    localparam int TW = $clog2(MAX_TENURE) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(BG_TIMEOUT - 1);
    localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);

    typedef enum logic [2:0] {IDLE, REQUEST, WAIT_BUS, OWN, RELEASE} state_t;

    state_t state_q, state_d;
    logic [1:0] bg_sync_q, bg_sync_d, as_sync_q, as_sync_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [TW-1:0] ten_cnt_q, ten_cnt_d;
    logic win_q, win_d;
    logic bg_err_q, bg_err_d;
    logic abort_q, abort_d;
    logic bgs, ass, req_win, arb_win;

    always_comb begin
        bg_sync_d = {bg_sync_q[0], BG_IN};
        as_sync_d = {as_sync_q[0], AS_IN};
        bgs = bg_sync_q[1];
        ass = as_sync_q[1];
        req_win = win_q ? REQ1_IN : REQ0_IN;
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    always_comb begin
        last_d = (state_d == OWN && state_q != OWN) ? win_q : last_q;
        arb_win = (REQ0_IN && REQ1_IN) ? ~last_q : !REQ0_IN;
    end
    // Reset to 1 so that requester 0 wins the first tie
    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) last_q <= 1'b1;
        else last_q <= last_d;
    end
`else
    always_comb arb_win = !REQ0_IN;
`endif

    always_comb begin
        state_d = state_q;
        win_d = win_q;
        bg_err_d = bg_err_q && !CLEAR_ERR_IN;
        abort_d = 1'b0;
        if (!RUN_IN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bg_err_q && (REQ0_IN || REQ1_IN)) begin
                        state_d = REQUEST;
                        win_d = arb_win;
                    end
                end
                REQUEST: begin
                    if (!req_win) state_d = IDLE;
                    else if (bgs) state_d = WAIT_BUS;
                    else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = IDLE;
                        bg_err_d = 1'b1;
                    end
                end
                WAIT_BUS: begin
                    if (!req_win) state_d = IDLE;
                    else if (!ass) state_d = OWN;
                end
                OWN: begin
                    if (!req_win) state_d = RELEASE;
                    else if (ten_cnt_q == TEN_LAST) begin
                        state_d = RELEASE;
                        abort_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Counters restart on every state entry and cannot pass their limit
        wait_cnt_d = (state_q == REQUEST && state_d == REQUEST) ? wait_cnt_q + 1'b1 : '0;
        ten_cnt_d = (state_q == OWN && state_d == OWN) ? ten_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            state_q <= IDLE;
            bg_sync_q <= '0;
            as_sync_q <= '0;
            wait_cnt_q <= '0;
            ten_cnt_q <= '0;
            win_q <= 1'b0;
            bg_err_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bg_sync_q <= bg_sync_d;
            as_sync_q <= as_sync_d;
            wait_cnt_q <= wait_cnt_d;
            ten_cnt_q <= ten_cnt_d;
            win_q <= win_d;
            bg_err_q <= bg_err_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        BR = state_q == REQUEST || state_q == WAIT_BUS;
        BGACK = state_q == OWN || state_q == RELEASE;
        GNT0 = state_q == OWN && !win_q;
        GNT1 = state_q == OWN && win_q;
        BG_ERR = bg_err_q;
        ABORT = abort_q;
    end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: vector table plus hand sequences, expectations queued at drive time.
module tb_bus_master_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run, bg, as_in, req0, req1, clr;
    logic br, bgack, gnt0, gnt1, bg_err, abort;
    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [5:0] vin;
        logic [5:0] vexp;
        string name;
    } vec_t;
    typedef struct {
        logic [5:0] vexp;
        string name;
    } sb_t;

    vec_t tv[$];
    sb_t sb[$];
    logic [5:0] tie_exp[3];

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_BR = 6'b100000;
    localparam logic [5:0] O_G0 = 6'b011000;
    localparam logic [5:0] O_G1 = 6'b010100;
    localparam logic [5:0] O_REL = 6'b010000;
    localparam logic [5:0] O_ERR = 6'b000010;
    localparam logic [5:0] O_ABT = 6'b010001;

    always #5 clk = ~clk;

    bus_master_arbiter #(.BG_TIMEOUT(8), .MAX_TENURE(16)) dut (
        .MCLK_IN(clk), .RESET_n_IN(rst_n), .RUN_IN(run), .BG_IN(bg), .AS_IN(as_in),
        .REQ0_IN(req0), .REQ1_IN(req1), .CLEAR_ERR_IN(clr),
        .BR(br), .BGACK(bgack), .GNT0(gnt0), .GNT1(gnt1), .BG_ERR(bg_err), .ABORT(abort)
    );

    function automatic logic [5:0] vi(input bit r, input bit g, input bit a,
                                      input bit q0, input bit q1, input bit c);
        return {r, g, a, q0, q1, c};
    endfunction

    function automatic void add(input logic [5:0] vin, input logic [5:0] vexp, input string name);
        vec_t v;
        v.vin = vin;
        v.vexp = vexp;
        v.name = name;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic [5:0] vexp);
        logic [5:0] got;
        got = {br, bgack, gnt0, gnt1, bg_err, abort};
        applied++;
        if (got !== vexp) begin
            miscompares++;
            $display("FAIL %s: br/bgack/gnt0/gnt1/bg_err/abort got %b expected %b", name, got, vexp);
        end
    endtask

    task automatic drive(input logic [5:0] vin, input logic [5:0] vexp, input string name);
        sb_t e;
        {run, bg, as_in, req0, req1, clr} = vin;
        e.vexp = vexp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.vexp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        {run, bg, as_in, req0, req1, clr} = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        tie_exp[0] = O_G0; tie_exp[1] = O_G1; tie_exp[2] = O_G0;
`else
        tie_exp[0] = O_G0; tie_exp[1] = O_G0; tie_exp[2] = O_G0;
`endif
        for (int i = 0; i < 2; i++) add(vi(1,1,0,0,0,0), O_NONE, "tie bg settle");
        for (int g = 0; g < 3; g++) begin
            add(vi(1,1,0,1,1,0), O_BR, $sformatf("tie %0d request", g));
            add(vi(1,1,0,1,1,0), O_BR, $sformatf("tie %0d wait_bus", g));
            add(vi(1,1,0,1,1,0), tie_exp[g], $sformatf("tie %0d grant", g));
            add(vi(1,1,0,0,0,0), O_REL, $sformatf("tie %0d release", g));
            add(vi(1,1,0,0,0,0), O_NONE, $sformatf("tie %0d idle", g));
        end
        for (int i = 0; i < 2; i++) add(vi(1,0,0,0,0,0), O_NONE, "bg flush");
        add(vi(1,0,0,1,0,0), O_BR, "basic br rise");
        add(vi(1,0,0,1,0,0), O_BR, "basic request");
        for (int i = 0; i < 3; i++) add(vi(1,1,0,1,0,0), O_BR, $sformatf("basic bg sync %0d", i));
        add(vi(1,1,0,1,0,0), O_G0, "basic grant");
        add(vi(1,1,0,1,0,0), O_G0, "basic own");
        add(vi(1,1,0,0,0,0), O_REL, "basic release");
        for (int i = 0; i < 3; i++) add(vi(1,0,0,0,0,0), O_NONE, $sformatf("basic idle %0d", i));
        for (int i = 0; i < 8; i++) add(vi(1,0,0,0,1,0), O_BR, $sformatf("timeout br %0d", i));
        add(vi(1,0,0,0,1,0), O_ERR, "timeout err set");
        for (int i = 0; i < 3; i++) add(vi(1,0,0,0,1,0), O_ERR, $sformatf("err blocks req %0d", i));
        add(vi(1,0,0,0,1,1), O_NONE, "clear err");
        add(vi(1,0,0,0,1,0), O_BR, "rearbitrate after clear");
        add(vi(1,0,0,0,0,0), O_NONE, "req drop in request");
        for (int i = 0; i < 8; i++) add(vi(1,0,0,0,1,0), O_BR, $sformatf("timeout2 br %0d", i));
        add(vi(1,0,0,0,1,1), O_ERR, "timeout beats clear");
        add(vi(1,0,0,0,0,1), O_NONE, "clear err again");

        #12;
        check("reset outputs", O_NONE);
        rst_n = 1'b1;
        for (int i = 0; i < tv.size(); i++) drive(tv[i].vin, tv[i].vexp, tv[i].name);

        for (int i = 0; i < 2; i++) drive(vi(1,1,0,0,0,0), O_NONE, "tenure bg settle");
        drive(vi(1,1,0,0,1,0), O_BR, "tenure request");
        drive(vi(1,1,0,0,1,0), O_BR, "tenure wait_bus");
        for (int i = 0; i < 16; i++) drive(vi(1,1,0,0,1,0), O_G1, $sformatf("tenure own %0d", i));
        drive(vi(1,1,0,0,1,0), O_ABT, "tenure abort");
        drive(vi(1,1,0,0,1,0), O_NONE, "tenure gap idle");
        drive(vi(1,1,0,0,1,0), O_BR, "second request");
        drive(vi(1,1,0,0,1,0), O_BR, "second wait_bus");
        drive(vi(1,1,0,0,1,0), O_G1, "second grant");
        drive(vi(1,1,0,0,0,0), O_REL, "release without abort");
        drive(vi(1,1,0,0,0,0), O_NONE, "post release idle");

        drive(vi(1,1,0,1,0,0), O_BR, "run request");
        drive(vi(1,1,0,1,0,0), O_BR, "run wait_bus");
        drive(vi(1,1,0,1,0,0), O_G0, "run own");
        drive(vi(0,1,0,1,0,0), O_NONE, "run drop in own");
        drive(vi(0,1,0,1,0,0), O_NONE, "run low holds idle");
        drive(vi(1,1,0,1,0,0), O_BR, "rerun request");
        #2 rst_n = 1'b0;
        #1 check("async reset mid request", O_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) drive(vi(1,1,1,1,0,0), O_BR, $sformatf("as held %0d", i));
        drive(vi(1,1,0,1,0,0), O_BR, "as sync 1");
        drive(vi(1,1,0,1,0,0), O_BR, "as sync 2");
        drive(vi(1,1,0,1,0,0), O_G0, "as released grant");
        drive(vi(1,1,0,0,0,0), O_REL, "as release");
        drive(vi(1,1,0,0,0,0), O_NONE, "as idle");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
